fft_frame_ctrl: RTL

Frame sequencer that sits in front of the bit-reversal sort buffer in the FFT pipeline. It accepts complex samples from upstream on a valid/ready interface and packs them into fixed NUM-sample frames. It drives the sort buffer's sample index, data and valid. After the last frame it runs a drain phase so that frame is read out of the sort buffer.

---
 rtl/fft_frame_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: packs upstream valid/ready samples into NUM-sample frames
// for the bit-reversal sort buffer, then drains the buffer after the last frame.
// Optional build macro: FFT_CTRL_LAST_CHECK_EN enables the s_last framing check;
// without it s_last is ignored and err_framing stays 0.
module fft_frame_ctrl #(
    parameter int WIDTH   = 24,
    parameter int log2NUM = 4,
    parameter int NUM     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [WIDTH-1:0]   s_r,
    input  logic [WIDTH-1:0]   s_i,
    output logic [log2NUM-1:0] d_num,
    output logic [WIDTH-1:0]   din_r,
    output logic [WIDTH-1:0]   din_i,
    output logic               din_valid,
    output logic               frame_start,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic               err_underrun,
    output logic               err_framing,
    input  logic               clr_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // NUM is a power of two, so the last index is all ones
    localparam logic [log2NUM-1:0] IDX_LAST = {log2NUM{1'b1}};
    localparam logic [log2NUM-1:0] IDX_ZERO = {log2NUM{1'b0}};
    localparam logic [log2NUM-1:0] IDX_ONE  = {{(log2NUM-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [log2NUM-1:0] idx_r;
    logic [log2NUM-1:0] idx_nxt_s;
    logic               ready_s;
    logic               accept_s;
    logic               idx_last_s;
    logic               idx_zero_s;
    logic               underrun_ev_s;
    logic               framing_ev_s;

    assign idx_last_s = (idx_r == IDX_LAST);
    assign idx_zero_s = (idx_r == IDX_ZERO);
    assign s_ready    = ready_s;
    assign busy       = (state_r != ST_IDLE);

    // Next-state, index advance, ready and error-event decode
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        ready_s       = 1'b1;
        underrun_ev_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (s_valid) begin
                    state_nxt_s = ST_RUN;
                    idx_nxt_s   = IDX_ONE;
                end else begin
                    idx_nxt_s   = IDX_ZERO;
                end
            end
            ST_RUN: begin
                ready_s       = 1'b1;
                underrun_ev_s = ~s_valid;
                idx_nxt_s     = idx_r + IDX_ONE;
                if (idx_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // only drain slot 0 may start a back-to-back frame
                ready_s = idx_zero_s;
                if (idx_zero_s && s_valid) begin
                    state_nxt_s = ST_RUN;
                    idx_nxt_s   = IDX_ONE;
                end else if (idx_last_s) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end else begin
                    idx_nxt_s   = idx_r + IDX_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
        accept_s = s_valid & ready_s;
    end

`ifdef FFT_CTRL_LAST_CHECK_EN
    // s_last must coincide exactly with the frame's final index
    always_comb begin
        if (accept_s) begin
            framing_ev_s = (s_last != idx_last_s);
        end else begin
            framing_ev_s = 1'b0;
        end
    end
`else
    // framing check disabled: s_last is deliberately ignored
    always_comb begin
        framing_ev_s = 1'b0 & s_last;
    end
`endif

    // State and index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Registered sort-buffer interface, one cycle behind acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_num       <= IDX_ZERO;
            din_r       <= {WIDTH{1'b0}};
            din_i       <= {WIDTH{1'b0}};
            din_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            d_num       <= idx_r;
            din_r       <= accept_s ? s_r : {WIDTH{1'b0}};
            din_i       <= accept_s ? s_i : {WIDTH{1'b0}};
            din_valid   <= accept_s;
            frame_start <= accept_s & idx_zero_s;
        end
    end

    // Accepted-frame counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (accept_s && idx_zero_s) begin
            frame_cnt <= frame_cnt + 16'd1;
        end else begin
            frame_cnt <= frame_cnt;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underrun <= 1'b0;
            err_framing  <= 1'b0;
        end else begin
            if (underrun_ev_s) begin
                err_underrun <= 1'b1;
            end else if (clr_err) begin
                err_underrun <= 1'b0;
            end else begin
                err_underrun <= err_underrun;
            end
            if (framing_ev_s) begin
                err_framing <= 1'b1;
            end else if (clr_err) begin
                err_framing <= 1'b0;
            end else begin
                err_framing <= err_framing;
            end
        end
    end

endmodule
